qpu_exu_oitf: RTL

QPU_EXU_OITF -- requirements
Module: QPU_exu_oitf

---
 rtl/qpu_exu_oitf.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/qpu_exu_oitf.sv
// Outstanding-instruction tracking FIFO for the QPU execution unit.
// Each dispatched instruction that writes a register and/or drives qubits
// takes one entry at the tail and gives it back at the head when it retires.
// The match flags report RAW/WAW hazards against every entry still in flight.
// Optional feature macro: QPU_OITF_QF_MATCH_EN adds the per-entry qubit list
// and the qubit-overlap hazard flag. When it is undefined, oitfqf_match_dispql
// and ret_qubitlist are tied to 0.

`ifndef QPU_RFIDX_REAL_WIDTH
`define QPU_RFIDX_REAL_WIDTH 5
`endif
`ifndef QPU_QUBIT_NUM
`define QPU_QUBIT_NUM 6
`endif

module qpu_exu_oitf #(
    parameter int OITF_DEPTH = 4,
    parameter int OITF_PTR_W = 2
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic                             disp_oitf_ena,
    output logic                             disp_oitf_ready,
    input  logic                             disp_oitf_rs1en,
    input  logic                             disp_oitf_rs2en,
    input  logic                             disp_oitf_rdwen,
    input  logic                             disp_oitf_qfren,
    input  logic [`QPU_RFIDX_REAL_WIDTH-1:0] disp_oitf_rs1idx,
    input  logic [`QPU_RFIDX_REAL_WIDTH-1:0] disp_oitf_rs2idx,
    input  logic [`QPU_RFIDX_REAL_WIDTH-1:0] disp_oitf_rdidx,
    input  logic [`QPU_QUBIT_NUM-1:0]        disp_oitf_qubitlist,

    output logic [OITF_PTR_W-1:0]            dis_ptr,
    output logic [OITF_PTR_W-1:0]            ret_ptr,

    input  logic                             ret_ena,
    output logic                             ret_rdwen,
    output logic [`QPU_RFIDX_REAL_WIDTH-1:0] ret_rdidx,
    output logic [`QPU_QUBIT_NUM-1:0]        ret_qubitlist,

    output logic                             oitf_empty,
    output logic                             oitfrd_match_disprs1,
    output logic                             oitfrd_match_disprs2,
    output logic                             oitfrd_match_disprd,
    output logic                             oitfqf_match_dispql
);

    localparam logic [OITF_PTR_W-1:0] LAST_IDX = OITF_PTR_W'(OITF_DEPTH - 1);

    // Pointer state: index plus a wrap flag so full and empty are distinguishable.
    logic [OITF_PTR_W-1:0]            r_dis_ptr;
    logic                             r_dis_flg;
    logic [OITF_PTR_W-1:0]            r_ret_ptr;
    logic                             r_ret_flg;
    logic [OITF_DEPTH-1:0]            r_vld;

    // Entry payload.
    logic                             r_rdwen [OITF_DEPTH];
    logic [`QPU_RFIDX_REAL_WIDTH-1:0] r_rdidx [OITF_DEPTH];

    logic                             w_full;
    logic                             w_empty;
    logic                             w_alloc;
    logic                             w_retire;

    assign w_full   = (r_dis_ptr == r_ret_ptr) & (r_dis_flg != r_ret_flg);
    assign w_empty  = (r_dis_ptr == r_ret_ptr) & (r_dis_flg == r_ret_flg);
    // A full FIFO never accepts, even if the head retires in the same cycle.
    assign w_alloc  = disp_oitf_ena & ~w_full;
    assign w_retire = ret_ena & ~w_empty;

    assign disp_oitf_ready = ~w_full;
    assign oitf_empty      = w_empty;
    assign dis_ptr         = r_dis_ptr;
    assign ret_ptr         = r_ret_ptr;
    assign ret_rdwen       = r_rdwen[r_ret_ptr];
    assign ret_rdidx       = r_rdidx[r_ret_ptr];

    // Advance tail/head pointers and maintain entry valid bits.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dis_ptr <= '0;
            r_dis_flg <= 1'b0;
            r_ret_ptr <= '0;
            r_ret_flg <= 1'b0;
            r_vld     <= '0;
        end else begin
            if (w_alloc) begin
                r_vld[r_dis_ptr] <= 1'b1;
                if (r_dis_ptr == LAST_IDX) begin
                    r_dis_ptr <= '0;
                    r_dis_flg <= ~r_dis_flg;
                end else begin
                    r_dis_ptr <= r_dis_ptr + 1'b1;
                end
            end
            // Retire never targets the allocated slot: allocation needs not-full,
            // retire needs not-empty, so the two indices differ when both fire.
            if (w_retire) begin
                r_vld[r_ret_ptr] <= 1'b0;
                if (r_ret_ptr == LAST_IDX) begin
                    r_ret_ptr <= '0;
                    r_ret_flg <= ~r_ret_flg;
                end else begin
                    r_ret_ptr <= r_ret_ptr + 1'b1;
                end
            end
        end
    end

    // Capture the payload of the entry being allocated.
    // NOTE: payload storage has no reset; it is only observed through a set
    // vld bit, so clearing it would add reset fan-out for no behaviour change.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_rdwen[r_dis_ptr] <= disp_oitf_rdwen;
            r_rdidx[r_dis_ptr] <= disp_oitf_rdidx;
        end
    end

    // Register-index hazard detection against registered entries only.
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        oitfrd_match_disprs1 = 1'b0;
        oitfrd_match_disprs2 = 1'b0;
        oitfrd_match_disprd  = 1'b0;
        for (int i = 0; i < OITF_DEPTH; i++) begin
            if (r_vld[i] && r_rdwen[i]) begin
                if (disp_oitf_rs1en && (r_rdidx[i] == disp_oitf_rs1idx))
                    oitfrd_match_disprs1 = 1'b1;
                if (disp_oitf_rs2en && (r_rdidx[i] == disp_oitf_rs2idx))
                    oitfrd_match_disprs2 = 1'b1;
                if (disp_oitf_rdwen && (r_rdidx[i] == disp_oitf_rdidx))
                    oitfrd_match_disprd  = 1'b1;
            end
        end
    end

`ifdef QPU_OITF_QF_MATCH_EN
    logic                             r_qfren     [OITF_DEPTH];
    logic [`QPU_QUBIT_NUM-1:0]        r_qubitlist [OITF_DEPTH];

    assign ret_qubitlist = r_qubitlist[r_ret_ptr];

    // Capture the qubit payload of the entry being allocated.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_qfren[r_dis_ptr]     <= disp_oitf_qfren;
            r_qubitlist[r_dis_ptr] <= disp_oitf_qubitlist;
        end
    end

    // Flag any in-flight qubit-writing entry whose qubits overlap the dispatch.
    always_comb begin
        oitfqf_match_dispql = 1'b0;
        for (int i = 0; i < OITF_DEPTH; i++) begin
            if (r_vld[i] && r_qfren[i] && (|(r_qubitlist[i] & disp_oitf_qubitlist)))
                oitfqf_match_dispql = 1'b1;
        end
    end
`else
    // Qubit tracking disabled: inputs are intentionally ignored.
    logic w_unused_qf;
    assign w_unused_qf         = disp_oitf_qfren ^ (^disp_oitf_qubitlist);
    assign ret_qubitlist       = '0;
    assign oitfqf_match_dispql = 1'b0;
`endif

endmodule
